// File: rtl/tc_delay_buffer.sv
// Programmable sample delay line over a circular buffer with FILL/RUN priming.
// Optional macro TC_ZERO_FILL_EN: emit zero-valued samples while filling.
module tc_delay_buffer #(
    parameter int DATA_W    = 16,
    parameter int CH_NUM    = 2,
    parameter int ADDR_W    = 10,
    parameter int DELAY_DEF = 69
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [CH_NUM*DATA_W-1:0] din,
    input  logic [ADDR_W-1:0]        delay_cfg,
    input  logic                     delay_load,
    output logic [CH_NUM*DATA_W-1:0] dout,
    output logic                     dout_valid,
    output logic                     tc_ready,
    output logic [ADDR_W-1:0]        delay_q
);
    localparam int WORD_W = CH_NUM * DATA_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DELAY_RST_I = (DELAY_DEF < 1) ? 1 :
                                 (DELAY_DEF > DEPTH - 1) ? DEPTH - 1 : DELAY_DEF;
    localparam logic [ADDR_W-1:0] DELAY_RST = ADDR_W'(DELAY_RST_I);

    typedef enum logic {FILL, RUN} state_t;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] fill_next;
    logic [ADDR_W-1:0] cfg_clamped;
    state_t            state;

    // delay_q >= 1 keeps the read address distinct from the write address
    assign rd_addr     = wr_ptr - delay_q;
    assign fill_next   = fill_cnt + ADDR_W'(1);
    assign cfg_clamped = (delay_cfg == '0) ? ADDR_W'(1) : delay_cfg;

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            fill_cnt   <= '0;
            delay_q    <= DELAY_RST;
            wr_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            tc_ready   <= 1'b0;
        end else begin
            tc_ready <= (state == RUN);
            if (in_valid) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (delay_load) begin
                // The load-cycle sample counts toward the new fill
                delay_q    <= cfg_clamped;
                fill_cnt   <= in_valid ? ADDR_W'(1) : '0;
                state      <= (in_valid && cfg_clamped == ADDR_W'(1)) ? RUN : FILL;
                dout_valid <= 1'b0;
            end else begin
                case (state)
                    FILL: begin
                        if (in_valid) begin
                            fill_cnt <= fill_next;
                            if (fill_next == delay_q) begin
                                state <= RUN;
                            end
                        end
`ifdef TC_ZERO_FILL_EN
                        dout_valid <= in_valid;
                        if (in_valid) begin
                            dout <= '0;
                        end
`else
                        dout_valid <= 1'b0;
`endif
                    end
                    RUN: begin
                        dout_valid <= in_valid;
                        if (in_valid) begin
                            dout <= mem[rd_addr];
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tc_delay_buffer.sv
// Self-checking bench for tc_delay_buffer: directed table, corner sequences, random vs. sample-history model.
module tb_tc_delay_buffer;
    localparam int WW  = 32;
    localparam int AW0 = 10;
    localparam int AW1 = 4;
`ifdef TC_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v0 = 1'b0, ld0 = 1'b0, v1 = 1'b0, ld1 = 1'b0;
    logic [WW-1:0]  din0 = '0, din1 = '0;
    logic [AW0-1:0] cfg0 = '0;
    logic [AW1-1:0] cfg1 = '0;
    logic [WW-1:0]  dout0, dout1;
    logic           dv0, dv1, rdy0, rdy1;
    logic [AW0-1:0] dq0;
    logic [AW1-1:0] dq1;

    always #5 clk = ~clk;

    tc_delay_buffer #(.DATA_W(16), .CH_NUM(2), .ADDR_W(AW0), .DELAY_DEF(69)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .din(din0), .delay_cfg(cfg0),
        .delay_load(ld0), .dout(dout0), .dout_valid(dv0), .tc_ready(rdy0), .delay_q(dq0));

    tc_delay_buffer #(.DATA_W(16), .CH_NUM(2), .ADDR_W(AW1), .DELAY_DEF(69)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .din(din1), .delay_cfg(cfg1),
        .delay_load(ld1), .dout(dout1), .dout_valid(dv1), .tc_ready(rdy1), .delay_q(dq1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference: every accepted sample is logged; an output is sample (k - delay)
    // once at least 'delay' samples have arrived since the last reset/load.
    logic [WW-1:0] hist [2][4096];
    int unsigned   total [2];
    int unsigned   nsince [2];
    int unsigned   dly [2];
    logic [WW-1:0] m_dout [2];
    logic          m_dv [2];
    logic          m_rdy [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            total[i]  = 0;
            nsince[i] = 0;
            m_dout[i] = '0;
            m_dv[i]   = 1'b0;
            m_rdy[i]  = 1'b0;
        end
        dly[0] = 69;
        dly[1] = 15;
    endtask

    task automatic model_step(input int i, input logic v, input logic ld, input int cfg, input logic [WW-1:0] d);
        m_rdy[i] = (nsince[i] >= dly[i]);
        if (ld) begin
            m_dv[i]   = 1'b0;
            dly[i]    = (cfg == 0) ? 1 : cfg;
            nsince[i] = v ? 1 : 0;
        end else if (v) begin
            if (nsince[i] >= dly[i]) begin
                m_dout[i] = hist[i][(total[i] - dly[i]) % 4096];
                m_dv[i]   = 1'b1;
            end else begin
                if (ZF) begin
                    m_dout[i] = '0;
                    m_dv[i]   = 1'b1;
                end else begin
                    m_dv[i] = 1'b0;
                end
                nsince[i]++;
            end
        end else begin
            m_dv[i] = 1'b0;
        end
        if (v) begin
            hist[i][total[i] % 4096] = d;
            total[i]++;
        end
    endtask

    task automatic compare_all();
        chk("dout0",  64'(dout0), 64'(m_dout[0]));
        chk("dv0",    64'(dv0),   64'(m_dv[0]));
        chk("rdy0",   64'(rdy0),  64'(m_rdy[0]));
        chk("dq0",    64'(dq0),   64'(dly[0]));
        chk("dout1",  64'(dout1), 64'(m_dout[1]));
        chk("dv1",    64'(dv1),   64'(m_dv[1]));
        chk("rdy1",   64'(rdy1),  64'(m_rdy[1]));
        chk("dq1",    64'(dq1),   64'(dly[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            model_step(0, v0, ld0, int'(cfg0), din0);
            model_step(1, v1, ld1, int'(cfg1), din1);
        end
        #1;
        compare_all();
    endtask

    task automatic drive0(input logic v, input logic ld, input int cfg, input logic [WW-1:0] d);
        v0 = v; ld0 = ld; cfg0 = AW0'(cfg); din0 = d;
    endtask

    task automatic drive1(input logic v, input logic ld, input int cfg, input logic [WW-1:0] d);
        v1 = v; ld1 = ld; cfg1 = AW1'(cfg); din1 = d;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 0, '0);
        drive1(1'b0, 1'b0, 0, '0);
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_dout0", 64'(dout0), 64'(0));
        chk("rst_dv0",   64'(dv0),   64'(0));
        chk("rst_rdy0",  64'(rdy0),  64'(0));
        chk("rst_dq0",   64'(dq0),   64'(69));
        chk("rst_dq1",   64'(dq1),   64'(15));
        cycle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic           v;
        logic           ld;
        logic [AW0-1:0] cfg;
        logic [WW-1:0]  din;
        logic           exp_dv;
        logic [WW-1:0]  exp_dout;
        logic           exp_rdy;
    } vec_t;

    function automatic vec_t mk(input int v, input int ld, input int cfg, input int d,
                                input int edv, input int edo, input int erdy);
        vec_t r;
        r.v = v[0]; r.ld = ld[0]; r.cfg = AW0'(cfg); r.din = WW'(d);
        r.exp_dv = edv[0]; r.exp_dout = WW'(edo); r.exp_rdy = erdy[0];
        return r;
    endfunction

    vec_t tbl [10];

    initial begin
        int first_rdy, nval, dvcnt, first_dv, rdy_after;
        logic [WW-1:0] firstv [2];
        logic [WW-1:0] lastd;

        // Gapped input after a delay-3 load coincident with the first sample
        tbl[0] = mk(1, 1, 3, 10, 0,       0,  0);
        tbl[1] = mk(0, 0, 0, 0,  0,       0,  0);
        tbl[2] = mk(1, 0, 0, 11, int'(ZF), 0, 0);
        tbl[3] = mk(0, 0, 0, 0,  0,       0,  0);
        tbl[4] = mk(1, 0, 0, 12, int'(ZF), 0, 0);
        tbl[5] = mk(0, 0, 0, 0,  0,       0,  1);
        tbl[6] = mk(1, 0, 0, 13, 1,       10, 1);
        tbl[7] = mk(0, 0, 0, 0,  0,       10, 1);
        tbl[8] = mk(1, 0, 0, 14, 1,       11, 1);
        tbl[9] = mk(0, 0, 0, 0,  0,       11, 1);

        model_reset();
        cycle();
        apply_reset();

        for (int i = 0; i < 10; i++) begin
            drive0(tbl[i].v, tbl[i].ld, int'(tbl[i].cfg), tbl[i].din);
            cycle();
            chk("tbl_dv",   64'(dv0),   64'(tbl[i].exp_dv));
            chk("tbl_dout", 64'(dout0), 64'(tbl[i].exp_dout));
            chk("tbl_rdy",  64'(rdy0),  64'(tbl[i].exp_rdy));
        end

        // Stream din=n from reset with the default delay of 69
        apply_reset();
        first_rdy = -1;
        nval = 0;
        for (int n = 0; n < 76; n++) begin
            drive0(1'b1, 1'b0, 0, WW'(n));
            cycle();
            if (rdy0 && first_rdy < 0) first_rdy = n + 1;
            if (dv0) begin
                if (nval < 2) firstv[nval] = dout0;
                nval++;
            end
        end
        chk("ready_edge", 64'(first_rdy), 64'(70));
        chk("first_out0", 64'(firstv[0]), 64'(0));
        chk("first_out1", 64'(firstv[1]), 64'(1));
        chk("run_outs",   64'(nval),      64'(7));

        // Mid-RUN reload to 5 coincident with a sample
        drive0(1'b1, 1'b1, 5, WW'(76));
        cycle();
        dvcnt = 0;
        rdy_after = -1;
        lastd = '0;
        for (int n = 77; n < 82; n++) begin
            drive0(1'b1, 1'b0, 0, WW'(n));
            cycle();
            if (n == 77) rdy_after = int'(rdy0);
            if (dv0) begin
                dvcnt++;
                lastd = dout0;
            end
        end
        chk("reload_rdy_drop", 64'(rdy_after), 64'(0));
        chk("reload_dvcnt",    64'(dvcnt),     64'(1));
        chk("reload_lag5",     64'(lastd),     64'(76));
        for (int n = 82; n < 86; n++) begin
            drive0(1'b1, 1'b0, 0, WW'(n));
            cycle();
        end

        // Reset pulse during RUN, then refill
        apply_reset();
        first_dv = -1;
        lastd = '0;
        for (int k = 0; k < 72; k++) begin
            drive0(1'b1, 1'b0, 0, WW'(1000 + k));
            cycle();
            if (dv0 && first_dv < 0 && !ZF) begin
                first_dv = k;
                lastd = dout0;
            end
        end
`ifndef TC_ZERO_FILL_EN
        chk("refill_first_idx", 64'(first_dv), 64'(69));
        chk("refill_first_val", 64'(lastd),    64'(1000));
`endif

        // Clamp of zero delay: output is the previous sample
        drive0(1'b1, 1'b1, 0, 32'h0000_aaaa);
        cycle();
        chk("clamp_dq", 64'(dq0), 64'(1));
        drive0(1'b1, 1'b0, 0, 32'h0000_bbbb);
        cycle();
        chk("clamp_prev", 64'(dout0), 64'h0000_aaaa);
        chk("clamp_dv",   64'(dv0),   64'(1));
        idle();

        // Maximum delay on the 16-deep instance, wrapping wr_ptr 15->0
        drive1(1'b1, 1'b1, 15, WW'(500));
        cycle();
        chk("max_dq", 64'(dq1), 64'(15));
        for (int k = 501; k <= 520; k++) begin
            drive1(1'b1, 1'b0, 0, WW'(k));
            cycle();
            if (k == 515) chk("max_first", 64'(dout1), 64'(500));
        end
        chk("max_last", 64'(dout1), 64'(505));
        idle();

        // Delay 4 loaded without a sample, then five samples
        drive0(1'b0, 1'b1, 4, '0);
        cycle();
        for (int j = 0; j < 5; j++) begin
            drive0(1'b1, 1'b0, 0, WW'(2000 + j));
            cycle();
            if (j < 4) begin
                chk("zf_dv", 64'(dv0), 64'(ZF));
`ifdef TC_ZERO_FILL_EN
                chk("zf_dout", 64'(dout0), 64'(0));
`endif
            end else begin
                chk("zf_5th_dv",   64'(dv0),   64'(1));
                chk("zf_5th_dout", 64'(dout0), 64'(2000));
            end
        end

        // Random traffic on both instances
        for (int t = 0; t < 3000; t++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            drive0($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                   (sel == 0) ? 0 : (sel == 1) ? 1023 : int'($urandom_range(1, 80)), WW'($urandom));
            drive1($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                   int'($urandom_range(0, 15)), WW'($urandom));
            cycle();
        end
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
